// File: rtl/corr_int_ctrl.sv
// Integrate-and-dump sequencer for the early/late correlator and DLL chain.
// Aligns to PRN code epochs, gates the summation blocks over N epochs, and
// after every dump runs a fixed-latency post pipeline:
// squaring -> DLL filter update -> NCO correction load.
// Integration of the next period overlaps post-processing of the last one.
module corr_int_ctrl #(
  parameter int SQR_LAT  = 1,
  parameter int FILT_LAT = 2,
  parameter int CNT_W    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic             code_epoch,
  input  logic [CNT_W-1:0] cfg_int_epochs,
  input  logic             clr_ovr,
  output logic             acc_en,
  output logic             acc_load,
  output logic             dump,
  output logic             sqr_en,
  output logic             filt_en,
  output logic             nco_load,
  output logic [CNT_W-1:0] epoch_cnt,
  output logic [15:0]      dump_count,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_INTEG = 2'd2
  } state_t;

  // Post pipeline position counter: 1 on the cycle after a dump, counting up
  // to POST_LEN (the nco_load cycle), 0 when idle.
  localparam int PW       = 6;
  localparam int POST_LEN = SQR_LAT + FILT_LAT + 1;
  localparam logic [PW-1:0] LEN_C     = PW'(POST_LEN);
  localparam logic [PW-1:0] SQR_END_C = PW'(SQR_LAT);
  localparam logic [PW-1:0] FILT_AT_C = PW'(SQR_LAT + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] n_reg;
  logic [PW-1:0]    post_cnt_reg;
  logic [PW-1:0]    post_next;
  logic             epoch_evt;

  // code_epoch only counts when it coincides with a real sample
  assign epoch_evt = code_epoch & sample_valid;
  assign state     = state_reg;

  // Accumulator control and dump strobe, same cycle as the epoch event
  always_comb begin
    acc_en   = 1'b0;
    acc_load = 1'b0;
    dump     = 1'b0;
    if (enable) begin
      case (state_reg)
        S_ALIGN: begin
          if (epoch_evt) begin
            acc_en   = 1'b1;
            acc_load = 1'b1;
          end
        end
        S_INTEG: begin
          acc_en = sample_valid;
          if (epoch_evt && (epoch_cnt >= n_reg)) begin
            dump     = 1'b1;
            acc_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next post pipeline position; a new dump always restarts it, dropping
  // any update still in flight
  always_comb begin
    post_next = '0;
    if (dump) begin
      post_next = PW'(1);
    end else if ((post_cnt_reg != '0) && (post_cnt_reg != LEN_C)) begin
      post_next = post_cnt_reg + PW'(1);
    end
  end

  // Sequencer FSM, epoch/dump counters, post pipeline strobes and overrun flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= S_IDLE;
      n_reg        <= CNT_W'(1);
      epoch_cnt    <= '0;
      dump_count   <= '0;
      post_cnt_reg <= '0;
      busy         <= 1'b0;
      sqr_en       <= 1'b0;
      filt_en      <= 1'b0;
      nco_load     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // a dump while busy beats a simultaneous clear
      if (dump && busy) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      if (!enable) begin
        state_reg    <= S_IDLE;
        epoch_cnt    <= '0;
        post_cnt_reg <= '0;
        busy         <= 1'b0;
        sqr_en       <= 1'b0;
        filt_en      <= 1'b0;
        nco_load     <= 1'b0;
      end else begin
        post_cnt_reg <= post_next;
        busy         <= (post_next != '0);
        sqr_en       <= (post_next != '0) && (post_next <= SQR_END_C);
        filt_en      <= (post_next == FILT_AT_C);
        nco_load     <= (post_next == LEN_C);

        case (state_reg)
          S_IDLE: begin
            state_reg <= S_ALIGN;
          end
          S_ALIGN: begin
            // a zero epoch count means a single-epoch integration
            n_reg <= (cfg_int_epochs == '0) ? CNT_W'(1) : cfg_int_epochs;
            if (epoch_evt) begin
              epoch_cnt <= CNT_W'(1);
              state_reg <= S_INTEG;
            end
          end
          S_INTEG: begin
            if (epoch_evt) begin
              if (dump) begin
                epoch_cnt  <= CNT_W'(1);
                dump_count <= dump_count + 16'd1;
              end else begin
                epoch_cnt <= epoch_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_corr_int_ctrl.sv
// Self-checking bench for corr_int_ctrl: a per-cycle vector table for epoch
// counting and the short post pipeline, plus directed sequences for reset,
// periodic dumps, overrun with long latencies, and enable drop.
module tb_corr_int_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, sv, ce, clr;
  logic [4:0] cfg;

  logic       a_acc_en, a_acc_load, a_dump, a_sqr_en, a_filt_en, a_nco_load;
  logic [4:0] a_epoch_cnt;
  logic [15:0] a_dump_count;
  logic       a_busy, a_overrun;
  logic [1:0] a_state;

  logic       b_acc_en, b_acc_load, b_dump, b_sqr_en, b_filt_en, b_nco_load;
  logic [4:0] b_epoch_cnt;
  logic [15:0] b_dump_count;
  logic       b_busy, b_overrun;
  logic [1:0] b_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  corr_int_ctrl #(.SQR_LAT(1), .FILT_LAT(2), .CNT_W(5)) dut_a (
    .CLK(clk), .RST(rst_n), .enable(en), .sample_valid(sv), .code_epoch(ce),
    .cfg_int_epochs(cfg), .clr_ovr(clr),
    .acc_en(a_acc_en), .acc_load(a_acc_load), .dump(a_dump), .sqr_en(a_sqr_en),
    .filt_en(a_filt_en), .nco_load(a_nco_load), .epoch_cnt(a_epoch_cnt),
    .dump_count(a_dump_count), .busy(a_busy), .overrun(a_overrun), .state(a_state)
  );

  corr_int_ctrl #(.SQR_LAT(15), .FILT_LAT(15), .CNT_W(5)) dut_b (
    .CLK(clk), .RST(rst_n), .enable(en), .sample_valid(sv), .code_epoch(ce),
    .cfg_int_epochs(cfg), .clr_ovr(clr),
    .acc_en(b_acc_en), .acc_load(b_acc_load), .dump(b_dump), .sqr_en(b_sqr_en),
    .filt_en(b_filt_en), .nco_load(b_nco_load), .epoch_cnt(b_epoch_cnt),
    .dump_count(b_dump_count), .busy(b_busy), .overrun(b_overrun), .state(b_state)
  );

  typedef struct {
    logic       en, sv, ce;
    logic [4:0] cfg;
    logic [1:0] st;
    logic       ae, al, dp;
    logic [4:0] ec;
    logic [15:0] dc;
    logic       by, sq, fe, nl;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input int e, s, c, f, st, ae, al, dp, ec, dc,
                              by, sq, fe, nl);
    vec_t v;
    v.en = e[0]; v.sv = s[0]; v.ce = c[0]; v.cfg = f[4:0];
    v.st = st[1:0]; v.ae = ae[0]; v.al = al[0]; v.dp = dp[0];
    v.ec = ec[4:0]; v.dc = dc[15:0];
    v.by = by[0]; v.sq = sq[0]; v.fe = fe[0]; v.nl = nl[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end else begin
      $display("[TB] ok %s[%0d] = %0h", nm, idx, act);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sv = 1'b0; ce = 1'b0; clr = 1'b0; cfg = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] act, exp;
    int last_d, ndump;

    // --- Table: N=4 counting, ignored epochs, cfg change, cfg=0, pipeline
    vecs[0]  = mk(1,0,0,4, 0,0,0,0,0,0, 0,0,0,0);
    vecs[1]  = mk(1,1,0,4, 1,0,0,0,0,0, 0,0,0,0);
    vecs[2]  = mk(1,1,1,4, 1,1,1,0,0,0, 0,0,0,0);
    vecs[3]  = mk(1,1,0,4, 2,1,0,0,1,0, 0,0,0,0);
    vecs[4]  = mk(1,0,1,4, 2,0,0,0,1,0, 0,0,0,0);
    vecs[5]  = mk(1,1,1,7, 2,1,0,0,1,0, 0,0,0,0);
    vecs[6]  = mk(1,1,1,7, 2,1,0,0,2,0, 0,0,0,0);
    vecs[7]  = mk(1,1,1,7, 2,1,0,0,3,0, 0,0,0,0);
    vecs[8]  = mk(1,0,0,7, 2,0,0,0,4,0, 0,0,0,0);
    vecs[9]  = mk(1,1,1,7, 2,1,1,1,4,0, 0,0,0,0);
    vecs[10] = mk(1,1,0,7, 2,1,0,0,1,1, 1,1,0,0);
    vecs[11] = mk(1,1,0,7, 2,1,0,0,1,1, 1,0,1,0);
    vecs[12] = mk(1,1,0,7, 2,1,0,0,1,1, 1,0,0,0);
    vecs[13] = mk(1,1,0,7, 2,1,0,0,1,1, 1,0,0,1);
    vecs[14] = mk(1,1,0,7, 2,1,0,0,1,1, 0,0,0,0);
    vecs[15] = mk(0,0,0,7, 2,0,0,0,1,1, 0,0,0,0);
    vecs[16] = mk(0,0,0,0, 0,0,0,0,0,1, 0,0,0,0);
    vecs[17] = mk(1,0,0,0, 0,0,0,0,0,1, 0,0,0,0);
    vecs[18] = mk(1,0,0,0, 1,0,0,0,0,1, 0,0,0,0);
    vecs[19] = mk(1,1,1,0, 1,1,1,0,0,1, 0,0,0,0);
    vecs[20] = mk(1,1,1,0, 2,1,1,1,1,1, 0,0,0,0);
    vecs[21] = mk(1,1,0,0, 2,1,0,0,1,2, 1,1,0,0);

    // --- Test 1: async reset in the middle of an integration
    do_reset();
    en = 1'b1; cfg = 5'd4; sv = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ce = (c >= 3);
      next_cycle();
    end
    ce = 1'b0;
    #2;
    chk("pre_reset_epoch", 0, {62'd0, a_state}, 64'd2);
    chk("pre_reset_cnt", 0, {59'd0, a_epoch_cnt}, 64'd3);
    rst_n = 1'b0;
    #1;
    act = {a_state, a_acc_en, a_acc_load, a_dump, a_epoch_cnt, a_dump_count,
           a_busy, a_sqr_en, a_filt_en, a_nco_load, a_overrun};
    chk("async_reset_outputs", 0, act, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    #3;
    chk("reset_release_state", 0, {62'd0, a_state}, 64'd0);
    next_cycle();
    chk("reenable_align", 0, {62'd0, a_state}, 64'd1);

    // --- Table-driven vectors
    do_reset();
    for (int i = 0; i < 22; i++) begin
      en = vecs[i].en; sv = vecs[i].sv; ce = vecs[i].ce; cfg = vecs[i].cfg;
      #4;
      act = {33'd0, a_state, a_acc_en, a_acc_load, a_dump, a_epoch_cnt,
             a_dump_count, a_busy, a_sqr_en, a_filt_en, a_nco_load};
      exp = {33'd0, vecs[i].st, vecs[i].ae, vecs[i].al, vecs[i].dp, vecs[i].ec,
             vecs[i].dc, vecs[i].by, vecs[i].sq, vecs[i].fe, vecs[i].nl};
      chk("vec", i, act, exp);
      next_cycle();
    end

    // --- Test 2: N=1, epoch every 100 cycles, short pipeline timing
    do_reset();
    en = 1'b1; cfg = 5'd1; sv = 1'b1;
    last_d = -1000; ndump = 0;
    for (int c = 0; c < 400; c++) begin
      int ofs;
      logic ed;
      ce = ((c % 100) == 10);
      ed = ce && (c > 10);
      ofs = c - last_d;
      #4;
      act = {a_dump, a_acc_load, a_sqr_en, a_filt_en, a_nco_load, a_busy, a_dump_count};
      exp = {ed, ce, (ofs == 1), (ofs == 2), (ofs == 4), (ofs >= 1 && ofs <= 4),
             16'(ndump)};
      if (ce || (ofs >= 0 && ofs <= 5)) chk("periodic", c, act, exp);
      if (ed) begin
        last_d = c;
        ndump++;
      end
      next_cycle();
    end
    ce = 1'b0;
    #4;
    chk("periodic_dump_count", 0, {48'd0, a_dump_count}, 64'd3);
    next_cycle();

    // --- Test 5: long pipeline, overrun, clr_ovr priority
    do_reset();
    en = 1'b1; cfg = 5'd1; sv = 1'b1;
    for (int c = 0; c < 86; c++) begin
      logic eo;
      ce  = (c == 5) || (c == 15) || (c == 25) || (c == 50);
      clr = (c == 45) || (c == 50);
      eo  = (c >= 26 && c <= 45) || (c >= 51);
      #4;
      act = {b_dump, b_overrun, b_filt_en, b_nco_load};
      exp = {(c == 15 || c == 25 || c == 50), eo, (c == 41 || c == 66), (c == 81)};
      if (c == 15 || c == 25 || c == 26 || (c >= 30 && c <= 52) || c == 66 || c >= 79)
        chk("overrun_seq", c, act, exp);
      next_cycle();
    end
    ce = 1'b0; clr = 1'b0;
    #4;
    chk("overrun_dump_count", 0, {48'd0, b_dump_count}, 64'd3);
    next_cycle();

    // --- Test 6: enable drops one cycle after a dump
    do_reset();
    en = 1'b1; cfg = 5'd1; sv = 1'b1;
    for (int c = 0; c < 19; c++) begin
      ce = (c == 3) || (c == 8) || (c == 17);
      en = !(c >= 9 && c <= 14);
      #4;
      if (c == 8) chk("drop_dump", c, {63'd0, a_dump}, 64'd1);
      if (c == 9) chk("drop_busy", c, {62'd0, a_busy, a_sqr_en}, 64'd3);
      if (c >= 10 && c <= 14)
        chk("drop_quiet", c, {44'd0, a_state, a_busy, a_filt_en, a_nco_load, a_dump_count},
            {44'd0, 2'd0, 3'd0, 16'd1});
      if (c == 16) chk("drop_realign", c, {62'd0, a_state}, 64'd1);
      if (c == 17)
        chk("drop_first_epoch", c, {61'd0, a_acc_en, a_acc_load, a_dump}, 64'd6);
      if (c == 18)
        chk("drop_resume", c, {41'd0, a_state, a_epoch_cnt, a_dump_count},
            {41'd0, 2'd2, 5'd1, 16'd1});
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/corr_int_ctrl.md
Name: corr_int_ctrl

Overview:
- Integrate-and-dump sequencer for the early/late correlator and DLL chain.
- Aligns to PRN code epochs and gates/loads the summation blocks for a configurable number of 1 ms epochs.
- At each integration end it issues a dump, then sequences squaring enable, the DLL filter update and the NCO correction load.
- Integration of the next period runs concurrently with post-processing of the previous one.

Parameters:
SQR_LAT, 1, cycles the squaring/adder stage needs sqr_en held after a dump (1..15)
FILT_LAT, 2, cycles from filt_en pulse to a valid dll_filter correction (1..15)
CNT_W, 5, width of epoch-count configuration and counter

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
enable  in  1  level; tracking enabled
sample_valid  in  1  data_in sample present this cycle
code_epoch  in  1  single-cycle pulse marking the first sample of a PRN code period; qualified by sample_valid
cfg_int_epochs  in  CNT_W  epochs per integration; 0 treated as 1; sampled only in ALIGN
clr_ovr  in  1  clears overrun flag
acc_en  out  1  summation blocks accumulate this cycle
acc_load  out  1  summation blocks load input instead of adding (start of period)
dump  out  1  1-cycle pulse; summation outputs hold the completed period's sum and must be captured
sqr_en  out  1  squaring/adder enable
filt_en  out  1  1-cycle dll_filter update strobe
nco_load  out  1  1-cycle strobe: NCO takes correction
epoch_cnt  out  CNT_W  epochs accumulated in current period (1..N)
dump_count  out  16  completed integrations, wraps 0xFFFF->0
busy  out  1  post-processing pipeline active
overrun  out  1  sticky: dump while busy
state  out  2  IDLE=0, ALIGN=1, INTEGRATE=2

Behaviour:
- Reset (RST=0, async): all outputs 0; state IDLE; latched N=1.
- Epoch event E = code_epoch & sample_valid. code_epoch without sample_valid is ignored.
- IDLE:
  - All strobes 0.
  - enable=1 -> ALIGN on the next edge.
- ALIGN:
  - Latch N = max(cfg_int_epochs, 1) every cycle.
  - On E: acc_en=1 and acc_load=1 (combinational, same cycle); epoch_cnt<=1; -> INTEGRATE. No dump.
- INTEGRATE:
  - acc_en = sample_valid.
  - On E with epoch_cnt<N: epoch_cnt++.
  - On E with epoch_cnt==N: dump=1, acc_load=1, acc_en=1 in that same cycle.
    - Summation blocks present the pre-load sum on dump, then load the new sample.
    - epoch_cnt<=1; dump_count++.
  - N is fixed until the next ALIGN.
- enable=0 in any state:
  - -> IDLE next edge; epoch_cnt<=0; post pipeline aborted (busy, sqr_en <=0).
  - No dump or filt_en/nco_load is issued after the edge where enable is seen low.
  - dump_count and overrun are kept.
- Post pipeline, dump at cycle t:
  - sqr_en high for cycles t+1 .. t+SQR_LAT.
  - filt_en pulse at t+SQR_LAT+1.
  - nco_load pulse at t+SQR_LAT+1+FILT_LAT.
  - busy high t+1 .. nco_load cycle inclusive.
  - Total dump->nco_load latency = SQR_LAT+FILT_LAT+1.
- Overrun:
  - Dump while busy=1 (including on the nco_load cycle): overrun<=1; pipeline restarts from t+1; the older update is dropped (no filt_en/nco_load for it).
  - clr_ovr=1 clears overrun; a simultaneous overrun event wins (stays 1).
- Registered outputs: epoch_cnt, dump_count, busy, sqr_en, filt_en, nco_load, overrun, state. acc_en, acc_load and dump are combinational from state and inputs.

Test Plan:
1. Reset mid-INTEGRATE (epoch_cnt=3) -> all outputs 0 immediately, state=0; after release with enable=1, state=1 next cycle.
2. N=1, SQR_LAT=1, FILT_LAT=2, E every 100 cycles starting t0:
   - First E: acc_load only, no dump.
   - Each later E: dump+acc_load.
   - sqr_en at dump+1; filt_en at dump+2; nco_load at dump+4; busy 4 cycles.
   - dump_count increments per dump.
3. cfg_int_epochs=4, five E events -> epoch_cnt 1,2,3,4 then dump on the 5th E with epoch_cnt->1.
   - Changing cfg to 7 mid-period has no effect until re-ALIGN.
   - cfg_int_epochs=0 behaves as 1.
4. code_epoch with sample_valid=0 -> no count, no dump.
   - sample_valid=0 gaps inside INTEGRATE -> acc_en=0 those cycles.
5. SQR_LAT=15, FILT_LAT=15, E spacing 10 cycles, N=1 -> overrun=1 at second dump and no filt_en before the restart.
   - clr_ovr pulsed with no overrun event -> overrun=0.
   - clr_ovr pulsed on a dump-while-busy cycle -> overrun stays 1.
6. enable drops 1 cycle after a dump -> no filt_en/nco_load; state IDLE; dump_count retained.
   - Re-enable -> ALIGN, first E gives acc_load without dump.
